router_fsm_nch: RTL and testbench
=================================

Name: router_fsm_nch

Overview:
- Parametrised packet-router control FSM for a 1xN router: decodes the header address, sequences header/payload/parity loading into the selected output FIFO, and handles FIFO-full back-pressure.
- Successor to the fixed 1x3 controller. Adds an N-channel select, per-channel status vectors, latched channel select, invalid-address packet drop, and a wait-for-empty timeout.
- Sits between the source interface and the register/synchroniser blocks of the router top.

Parameters:
- NUM_CH, 3: number of output channels/FIFOs (2..8).
- ADDR_W, 2: header address field width; must be >= clog2(NUM_CH).
- WAIT_MAX, 64: maximum cycles in WAIT_EMPTY before the packet is dropped (>= 2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- pkt_vd  in  1  packet valid from source.
- din  in  ADDR_W  header address bits (din[ADDR_W-1:0] of the header byte).
- fifo_full  in  NUM_CH  per-channel FIFO full.
- fifo_empty  in  NUM_CH  per-channel FIFO empty.
- sft_rst  in  NUM_CH  per-channel soft reset from the FIFO read-timeout logic.
- parity_done  in  1  parity byte written (register block).
- low_pkt_vd  in  1  pkt_vd fell while in FULL (register block).
- ch_sel  out  ADDR_W  latched destination channel.
- detect_add, lfd_state, ld_state, laf_state, full_state  out  1  state decodes.
- write_enb_reg  out  1  register-block write enable.
- rst_in_reg  out  1  parity-check/clear strobe.
- busy  out  1  stall source.
- drop_state  out  1  packet being discarded.
- wait_timeout  out  1  one-cycle pulse when WAIT_EMPTY times out.

Behaviour:
- States: DECODE, LFD, LD, WAIT_EMPTY, LP, CPE, FULL, LAF, DROP. Encoding is free, minimum 4 bits.
- Reset (rstn=0, asynchronous): state=DECODE, ch_sel=0, wait counter=0, wait_timeout=0.
- Outputs after reset: detect_add=1, busy=0, all other outputs 0.
- Let F=fifo_full[ch_sel] and E=fifo_empty[ch_sel]. In DECODE, din replaces ch_sel for the same-cycle decision.
- ch_sel latch: ch_sel <= din on any clock with state==DECODE and pkt_vd=1. Held in all other states.
- valid_addr = (din < NUM_CH).
- DECODE transitions:
  - pkt_vd & valid_addr & fifo_empty[din] -> LFD
  - pkt_vd & valid_addr & !fifo_empty[din] -> WAIT_EMPTY
  - pkt_vd & !valid_addr -> DROP
  - otherwise stay.
- LFD -> LD unconditionally.
- LD: F -> FULL; else !pkt_vd -> LP; else stay. F has priority.
- WAIT_EMPTY: checks only the selected channel's empty flag.
  - E -> LFD.
  - Else, when the counter reaches WAIT_MAX-1 -> DROP, with wait_timeout=1 for that one cycle (registered pulse, asserted the cycle DROP is entered).
  - Counter clears on entry to WAIT_EMPTY and increments each cycle in it.
- LP -> CPE unconditionally.
- CPE: F -> FULL, else DECODE.
- FULL: !F -> LAF, else stay.
- LAF: parity_done -> DECODE; else low_pkt_vd -> LP; else LD.
- DROP: !pkt_vd -> DECODE, else stay. No writes occur; busy=0 so the source drains.
- Soft reset: when sft_rst[ch_sel]=1 and state != DECODE, next state = DECODE. This overrides all transitions except rstn.
  - sft_rst of a non-selected channel has no effect.
  - sft_rst is ignored in DECODE.
- Outputs (Moore, combinational from state):
  - detect_add = DECODE; lfd_state = LFD; ld_state = LD; laf_state = LAF; full_state = FULL; drop_state = DROP.
  - write_enb_reg = LD | LP | LAF.
  - rst_in_reg = CPE.
  - busy = 0 in DECODE, LD, DROP; 1 in all other states.
- Unreachable encodings recover to DECODE on the next clock.
- rstn assertion mid-packet aborts immediately to DECODE, regardless of clock.

Test Plan:
- Happy path, NUM_CH=3: DECODE, pkt_vd=1, din=2, fifo_empty=3'b111. Hold pkt_vd 4 cycles, then drop it. Expect ch_sel=2; sequence LFD, LD x3, LP, CPE, DECODE. write_enb_reg high in LD/LP; busy=0 only in DECODE/LD; rst_in_reg one cycle.
- Back-pressure: in LD, assert fifo_full=3'b100 (ch 2) for 5 cycles. Expect FULL for 5 cycles with busy=1, then LAF. With parity_done=0 and low_pkt_vd=1, next state is LP.
- Invalid address: din=3 with pkt_vd=1 for 6 cycles. Expect DROP, drop_state=1, busy=0, write_enb_reg=0 throughout, then DECODE the cycle after pkt_vd falls.
- Wait timeout, WAIT_MAX=8: din=1, fifo_empty=3'b101 (ch 1 not empty, others empty). Expect WAIT_EMPTY for exactly 8 cycles with no advance from channels 0/2, then a 1-cycle wait_timeout pulse and DROP. Repeat with fifo_empty[1] rising at cycle 3: expect LFD, no pulse.
- Soft reset selectivity: in LD on ch 0, pulse sft_rst=3'b010 -> no change. Pulse sft_rst=3'b001 -> DECODE next clock.
- Async reset: drop rstn mid-FULL between clock edges. Expect immediate detect_add=1, busy=0, ch_sel=0, with no clock required.

Source files
------------

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: control FSM for a 1xN packet router.
// Decodes the header address, sequences header/payload/parity loading into
// the selected output FIFO, handles FIFO-full back-pressure, discards packets
// aimed at nonexistent channels, and gives up on a busy channel after a
// bounded wait for it to drain.
module router_fsm_nch #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 2,
  parameter int WAIT_MAX = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pkt_vd,
  input  logic [ADDR_W-1:0] din,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] sft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_vd,
  output logic [ADDR_W-1:0] ch_sel,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_in_reg,
  output logic              busy,
  output logic              drop_state,
  output logic              wait_timeout
);

  localparam int CNT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [ADDR_W:0]   NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [3:0] {
    DECODE     = 4'd0,
    LFD        = 4'd1,
    LD         = 4'd2,
    WAIT_EMPTY = 4'd3,
    LP         = 4'd4,
    CPE        = 4'd5,
    FULL       = 4'd6,
    LAF        = 4'd7,
    DROP       = 4'd8
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ch_sel_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wait_timeout_q;

  logic              valid_addr;
  logic              empty_din;
  logic              f_sel;
  logic              e_sel;
  logic              soft_rst;
  logic              timeout_hit;

  // Select one channel's flag; indices beyond NUM_CH read as 0 instead of X.
  function automatic logic pick(input logic [NUM_CH-1:0] vec,
                                input logic [ADDR_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == ADDR_W'(i)) r = vec[i];
    end
    return r;
  endfunction

  assign valid_addr = ({1'b0, din} < NUM_CH_L);
  assign empty_din  = pick(fifo_empty, din);
  // Outside DECODE the latched select decides which channel's flags matter.
  assign f_sel      = pick(fifo_full,  ch_sel_q);
  assign e_sel      = pick(fifo_empty, ch_sel_q);
  assign soft_rst   = (state_q != DECODE) && pick(sft_rst, ch_sel_q);

  // Next-state decision; soft reset of the active channel overrides everything.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      DECODE: begin
        if (pkt_vd) begin
          if (!valid_addr)    state_d = DROP;
          else if (empty_din) state_d = LFD;
          else                state_d = WAIT_EMPTY;
        end
      end
      LFD:        state_d = LD;
      LD: begin
        if (f_sel)        state_d = FULL;
        else if (!pkt_vd) state_d = LP;
      end
      WAIT_EMPTY: begin
        if (e_sel) begin
          state_d = LFD;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DROP;
          timeout_hit = 1'b1;
        end
      end
      LP:         state_d = CPE;
      CPE:        state_d = f_sel ? FULL : DECODE;
      FULL:       if (!f_sel) state_d = LAF;
      LAF: begin
        if (parity_done)     state_d = DECODE;
        else if (low_pkt_vd) state_d = LP;
        else                 state_d = LD;
      end
      DROP:       if (!pkt_vd) state_d = DECODE;
      default:    state_d = DECODE;
    endcase
    if (soft_rst) begin
      state_d     = DECODE;
      timeout_hit = 1'b0;
    end
  end

  // State, latched channel select, wait counter and timeout pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= DECODE;
      ch_sel_q       <= '0;
      cnt_q          <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q        <= state_d;
      wait_timeout_q <= timeout_hit;
      if (state_q == DECODE && pkt_vd) ch_sel_q <= din;
      if (state_q == WAIT_EMPTY) cnt_q <= cnt_q + 1'b1;
      else                       cnt_q <= '0;
    end
  end

  // Moore decodes straight from the state register.
  assign detect_add    = (state_q == DECODE);
  assign lfd_state     = (state_q == LFD);
  assign ld_state      = (state_q == LD);
  assign laf_state     = (state_q == LAF);
  assign full_state    = (state_q == FULL);
  assign drop_state    = (state_q == DROP);
  assign write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
  assign rst_in_reg    = (state_q == CPE);
  assign busy          = !((state_q == DECODE) || (state_q == LD) || (state_q == DROP));
  assign ch_sel        = ch_sel_q;
  assign wait_timeout  = wait_timeout_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed table-driven bench for router_fsm_nch
// (NUM_CH=3, ADDR_W=2, WAIT_MAX=8).
module tb_router_fsm_nch;

  typedef enum int {S_DEC, S_LFD, S_LD, S_WE, S_LP, S_CPE, S_FULL, S_LAF, S_DROP} exp_st_e;

  typedef struct {
    logic       pkt_vd;
    logic [1:0] din;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] sft;
    logic       pd;
    logic       lpv;
    exp_st_e    st;
    logic [1:0] ch;
    logic       wt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pkt_vd;
  logic [1:0] din;
  logic [2:0] fifo_full, fifo_empty, sft_rst;
  logic       parity_done, low_pkt_vd;
  logic [1:0] ch_sel;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_in_reg, busy, drop_state, wait_timeout;

  int n_pass = 0;
  int n_total = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_MAX(8)) dut (
    .clk(clk), .rstn(rstn), .pkt_vd(pkt_vd), .din(din),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .sft_rst(sft_rst),
    .parity_done(parity_done), .low_pkt_vd(low_pkt_vd), .ch_sel(ch_sel),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_in_reg(rst_in_reg), .busy(busy),
    .drop_state(drop_state), .wait_timeout(wait_timeout)
  );

  // Expected {detect,lfd,ld,laf,full,drop,wenb,rst_in,busy} for each state.
  function automatic logic [8:0] exp_out(input exp_st_e s);
    case (s)
      S_DEC:   return 9'b100000000;
      S_LFD:   return 9'b010000001;
      S_LD:    return 9'b001000100;
      S_WE:    return 9'b000000001;
      S_LP:    return 9'b000000101;
      S_CPE:   return 9'b000000011;
      S_FULL:  return 9'b000010001;
      S_LAF:   return 9'b000100101;
      S_DROP:  return 9'b000001000;
      default: return 9'b111111111;
    endcase
  endfunction

  function automatic logic [8:0] act_out();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            drop_state, write_enb_reg, rst_in_reg, busy};
  endfunction

  function automatic vec_t v(input logic p, input logic [1:0] d, input logic [2:0] f,
                             input logic [2:0] e, input logic [2:0] s, input logic pd,
                             input logic lpv, input exp_st_e st, input logic [1:0] ch,
                             input logic wt);
    vec_t r;
    r.pkt_vd = p; r.din = d; r.full = f; r.empty = e; r.sft = s;
    r.pd = pd; r.lpv = lpv; r.st = st; r.ch = ch; r.wt = wt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one vector, clock once, and compare the post-edge outputs.
  task automatic step(input string tag, input vec_t x);
    pkt_vd = x.pkt_vd; din = x.din; fifo_full = x.full; fifo_empty = x.empty;
    sft_rst = x.sft; parity_done = x.pd; low_pkt_vd = x.lpv;
    @(posedge clk); #1;
    check({tag, " outputs"}, 32'(act_out()), 32'(exp_out(x.st)));
    check({tag, " ch_sel"}, 32'(ch_sel), 32'(x.ch));
    check({tag, " wait_timeout"}, 32'(wait_timeout), 32'(x.wt));
  endtask

  initial begin
    rstn = 1'b0; pkt_vd = 1'b0; din = '0; fifo_full = '0; fifo_empty = '0;
    sft_rst = '0; parity_done = 1'b0; low_pkt_vd = 1'b0;

    // Happy path: header to ch 2, three payload cycles, parity, check.
    tbl.push_back(v(1, 2, 0, 7, 0, 0, 0, S_LFD,  2, 0));
    tbl.push_back(v(1, 0, 0, 7, 0, 0, 0, S_LD,   2, 0));
    tbl.push_back(v(1, 0, 0, 7, 0, 0, 0, S_LD,   2, 0));
    tbl.push_back(v(1, 0, 0, 7, 0, 0, 0, S_LD,   2, 0));
    tbl.push_back(v(0, 0, 0, 7, 0, 0, 0, S_LP,   2, 0));
    tbl.push_back(v(0, 0, 0, 7, 0, 0, 0, S_CPE,  2, 0));
    tbl.push_back(v(0, 0, 0, 7, 0, 0, 0, S_DEC,  2, 0));
    // Back-pressure on ch 2 for five cycles, then LAF -> LP via low_pkt_vd.
    tbl.push_back(v(1, 2, 0, 7, 0, 0, 0, S_LFD,  2, 0));
    tbl.push_back(v(1, 2, 0, 7, 0, 0, 0, S_LD,   2, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(1, 2, 4, 7, 0, 0, 0, S_FULL, 2, 0));
    tbl.push_back(v(1, 2, 0, 7, 0, 0, 0, S_LAF,  2, 0));
    tbl.push_back(v(0, 2, 0, 7, 0, 0, 1, S_LP,   2, 0));
    tbl.push_back(v(0, 2, 0, 7, 0, 0, 0, S_CPE,  2, 0));
    tbl.push_back(v(0, 2, 0, 7, 0, 0, 0, S_DEC,  2, 0));
    // Full on a non-selected channel is ignored; LAF with parity_done ends packet.
    tbl.push_back(v(1, 0, 0, 7, 0, 0, 0, S_LFD,  0, 0));
    tbl.push_back(v(1, 0, 6, 7, 0, 0, 0, S_LD,   0, 0));
    tbl.push_back(v(1, 0, 1, 7, 0, 0, 0, S_FULL, 0, 0));
    tbl.push_back(v(1, 0, 0, 7, 0, 0, 0, S_LAF,  0, 0));
    tbl.push_back(v(1, 0, 0, 7, 0, 1, 0, S_DEC,  0, 0));
    // Invalid address 3: discard while pkt_vd is high.
    for (int i = 0; i < 6; i++) tbl.push_back(v(1, 3, 0, 7, 0, 0, 0, S_DROP, 3, 0));
    tbl.push_back(v(0, 3, 0, 7, 0, 0, 0, S_DEC,  3, 0));
    // Soft reset: ignored in DECODE, ignored for other channel, honoured for ch 0.
    tbl.push_back(v(1, 0, 0, 7, 1, 0, 0, S_LFD,  0, 0));
    tbl.push_back(v(1, 0, 0, 7, 0, 0, 0, S_LD,   0, 0));
    tbl.push_back(v(1, 0, 0, 7, 2, 0, 0, S_LD,   0, 0));
    tbl.push_back(v(1, 0, 0, 7, 1, 0, 0, S_DEC,  0, 0));
    tbl.push_back(v(0, 0, 0, 7, 0, 0, 0, S_DEC,  0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 32'(act_out()), 32'(exp_out(S_DEC)));
    check("reset ch_sel", 32'(ch_sel), 32'd0);
    check("reset wait_timeout", 32'(wait_timeout), 32'd0);
    rstn = 1'b1;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Wait timeout: ch 1 never drains -> 8 cycles of WAIT_EMPTY, pulse, DROP.
    for (int i = 0; i < 8; i++) step($sformatf("wait%0d", i), v(1, 1, 0, 5, 0, 0, 0, S_WE, 1, 0));
    step("timeout", v(1, 1, 0, 5, 0, 0, 0, S_DROP, 1, 1));
    step("timeout+1", v(1, 1, 0, 5, 0, 0, 0, S_DROP, 1, 0));
    step("timeout exit", v(0, 1, 0, 5, 0, 0, 0, S_DEC, 1, 0));

    // Ch 1 drains on the third waiting cycle -> LFD with no pulse.
    for (int i = 0; i < 3; i++) step($sformatf("wait_b%0d", i), v(1, 1, 0, 5, 0, 0, 0, S_WE, 1, 0));
    step("drained", v(1, 1, 0, 7, 0, 0, 0, S_LFD, 1, 0));
    step("drained ld", v(1, 1, 0, 7, 0, 0, 0, S_LD, 1, 0));
    step("drained lp", v(0, 1, 0, 7, 0, 0, 0, S_LP, 1, 0));
    step("drained cpe", v(0, 1, 0, 7, 0, 0, 0, S_CPE, 1, 0));
    step("drained dec", v(0, 1, 0, 7, 0, 0, 0, S_DEC, 1, 0));

    // Async reset in FULL, applied between clock edges.
    step("ar lfd", v(1, 2, 0, 7, 0, 0, 0, S_LFD, 2, 0));
    step("ar ld", v(1, 2, 0, 7, 0, 0, 0, S_LD, 2, 0));
    step("ar full", v(1, 2, 4, 7, 0, 0, 0, S_FULL, 2, 0));
    #2 rstn = 1'b0;
    #1;
    check("async outputs", 32'(act_out()), 32'(exp_out(S_DEC)));
    check("async ch_sel", 32'(ch_sel), 32'd0);
    pkt_vd = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("async held", 32'(act_out()), 32'(exp_out(S_DEC)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
